col_psum_accumulator: RTL and testbench
=======================================

Name: col_psum_accumulator

Overview:
- Downstream stage of the per-pixel multiplier column.
- Each accepted beat carries NO_COL_KERNEL signed products: one input-feature pixel times one kernel weight column.
- The block scatter-adds the products into a one-row partial-sum line buffer. Pixel p, product k adds to output position p+k. Sums accumulate over input channels.
- After the last pixel of the last channel, it drains the finished output row serially under a valid/ready handshake to the output/activation stage.

Parameters:
- BIT_WIDTH, 8: operand width; each product is 2*BIT_WIDTH bits, signed.
- NO_COL_KERNEL, 5: products per beat (kernel column height).
- NO_COL_INPUT, 8: input pixels per row.
- ACC_WIDTH, 20: accumulator width; must be at least 2*BIT_WIDTH.
- Derived OUT_W = NO_COL_INPUT+NO_COL_KERNEL-1, default 12.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_prod_col, input, 2*BIT_WIDTH*NO_COL_KERNEL: product k in bits [2*k*BIT_WIDTH +: 2*BIT_WIDTH].
- i_valid, input, 1: i_prod_col beat valid.
- i_last_ch, input, 1: current beat belongs to the last input channel; sampled only on the row's last pixel.
- o_ready, output, 1: block accepts beats; 1 only in ACCUM.
- o_data, output, ACC_WIDTH: drained partial sum, signed.
- o_valid, output, 1: o_data valid.
- i_ready, input, 1: downstream accepts o_data.
- o_last, output, 1: o_data is position OUT_W-1.
- o_pix_cnt, output, $clog2(NO_COL_INPUT): index of the next pixel expected.

Behaviour:
- Reset values (async on i_rst): state=ACCUM, all buffer entries 0, pixel counter 0, drain index 0, o_valid 0, o_last 0, o_data 0, o_ready 1. Reset asserted mid-row or mid-drain discards all content.
- States are ACCUM and DRAIN.
- ACCUM:
  - Beat accepted when i_valid && o_ready.
  - On accept with pixel p: buf[p+k] += sign_extend(product k) for k=0..NO_COL_KERNEL-1, all in the same cycle.
  - Arithmetic wraps modulo 2^ACC_WIDTH; no saturation.
  - The pixel counter increments on accept.
  - At p=NO_COL_INPUT-1 the counter wraps to 0.
    - If i_last_ch=1 on that beat, go to DRAIN next cycle.
    - Otherwise stay in ACCUM and accumulate the next channel on top.
  - i_valid while o_ready=0 is ignored: no update, no counter change.
- DRAIN:
  - o_ready=0.
  - o_valid=1 registered, starting the cycle after entry. o_data=buf[idx] with idx from 0.
  - o_data is held stable while i_valid... stable while o_valid && !i_ready.
  - Transfer when o_valid && i_ready. On transfer, buf[idx] is cleared to 0 and idx increments.
  - o_last=1 exactly when idx=OUT_W-1.
  - Transfer with o_last: o_valid drops next cycle, idx returns to 0, state returns to ACCUM, o_ready=1 that cycle.
- Latency:
  - Last accepted beat to first o_valid: 2 cycles (accumulate write, then register out).
  - Full drain: OUT_W transfers; no bubbles when i_ready is held at 1.
- Row done to next row: one idle cycle minimum between the last drain transfer and the next accepted beat.
- Buffer implemented as registers; no RAM inference required.

Test Plan:
- All products = 1 (0x0001), one channel, i_last_ch=1 on pixel 7, i_ready=1 → o_data sequence 1,2,3,4,5,5,5,5,4,3,2,1; o_last only on the 12th; o_ready returns 1 after.
- Same stimulus over two channels (i_last_ch=0 on the first pass) → 2,4,6,8,10,10,10,10,8,6,4,2; no o_valid after the first pass.
- All products = 0xFFFF (-1), one channel → o_data = 0xFFFFF, 0xFFFFE, … (two's-complement -1..-5 pattern); sign extension verified.
- Backpressure: i_ready toggled 1,0,0,1,… during drain → o_data/o_last stable while stalled, no value skipped or duplicated. i_valid=1 throughout drain → ignored; next row starts from clean zeros.
- Reset mid-drain after 5 transfers → o_valid=0 immediately (async), o_ready=1. A following single-channel all-ones row reproduces the first scenario exactly.
- i_valid gaps (valid every other cycle) → identical results to the first scenario; o_pix_cnt advances only on accepts.

Source files
------------

// File: rtl/col_psum_accumulator.sv
// Scatter-adds each beat of column products into a one-row partial-sum line buffer,
// then drains the finished row serially under a valid/ready handshake.
module col_psum_accumulator #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int NO_COL_INPUT  = 8,
    parameter int ACC_WIDTH     = 20,
    localparam int PW           = (NO_COL_INPUT > 1) ? $clog2(NO_COL_INPUT) : 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0] i_prod_col,
    input  logic                                 i_valid,
    input  logic                                 i_last_ch,
    output logic                                 o_ready,
    output logic [ACC_WIDTH-1:0]                 o_data,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic                                 o_last,
    output logic [PW-1:0]                        o_pix_cnt
);

    localparam int OUT_W = NO_COL_INPUT + NO_COL_KERNEL - 1;
    localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]                            state_q, state_d;
    logic [OUT_W-1:0][ACC_WIDTH-1:0]       buf_q, buf_d;
    logic [PW-1:0]                         pix_q, pix_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic                                  valid_q, valid_d;
    logic                                  last_q, last_d;
    logic [ACC_WIDTH-1:0]                  data_q, data_d;
    logic [NO_COL_KERNEL-1:0][ACC_WIDTH-1:0] prod_ext;
    logic                                  accept;
    logic                                  pix_last;

    for (genvar k = 0; k < NO_COL_KERNEL; k++) begin : g_ext
        assign prod_ext[k] = ACC_WIDTH'($signed(i_prod_col[2*k*BIT_WIDTH +: 2*BIT_WIDTH]));
    end

    assign o_ready   = (state_q == S_ACCUM);
    assign o_valid   = valid_q;
    assign o_last    = last_q;
    assign o_data    = data_q;
    assign o_pix_cnt = pix_q;
    assign accept    = i_valid && o_ready;
    assign pix_last  = (pix_q == PW'(NO_COL_INPUT - 1));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pix_d   = pix_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (state_q == S_ACCUM) begin
            if (accept) begin
                // Product k of pixel p lands on output position p+k.
                for (int j = 0; j < OUT_W; j++) begin
                    for (int k = 0; k < NO_COL_KERNEL; k++) begin
                        if (int'(pix_q) + k == j) buf_d[j] = buf_d[j] + prod_ext[k];
                    end
                end
                if (pix_last) begin
                    pix_d = '0;
                    if (i_last_ch) state_d = S_DRAIN;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
        end else begin
            if (!valid_q) begin
                valid_d = 1'b1;
                data_d  = buf_q[idx_q];
                last_d  = (idx_q == IW'(OUT_W - 1));
            end else if (i_ready) begin
                // Clear on transfer so the next row starts from zero.
                buf_d[idx_q] = '0;
                if (last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    data_d = buf_q[idx_d];
                    last_d = (idx_d == IW'(OUT_W - 1));
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_ACCUM;
            buf_q   <= '0;
            pix_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pix_q   <= pix_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_col_psum_accumulator.sv
// Directed bench for col_psum_accumulator: single/multi-channel rows, sign extension,
// backpressure, ignored beats during drain, async reset mid-drain, input gaps.
module tb_col_psum_accumulator;

    localparam int BW = 8;
    localparam int NK = 5;
    localparam int NI = 8;
    localparam int AW = 20;
    localparam int OW = NI + NK - 1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [2*BW*NK-1:0] i_prod_col;
    logic              i_valid;
    logic              i_last_ch;
    logic              o_ready;
    logic [AW-1:0]     o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic [2:0]        o_pix_cnt;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] e1 [OW];
    logic [AW-1:0] e2 [OW];
    logic [AW-1:0] e3 [OW];

    col_psum_accumulator #(
        .BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .NO_COL_INPUT(NI), .ACC_WIDTH(AW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_prod_col(i_prod_col), .i_valid(i_valid),
        .i_last_ch(i_last_ch), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_last(o_last), .o_pix_cnt(o_pix_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_row(input logic [15:0] pv, input logic lc, input bit gap);
        for (int p = 0; p < NI; p++) begin
            chk("pix_cnt", 32'(o_pix_cnt), p);
            chk("ready_accum", 32'(o_ready), 1);
            i_valid    = 1'b1;
            i_prod_col = {NK{pv}};
            i_last_ch  = lc && (p == NI - 1);
            step();
            i_valid   = 1'b0;
            i_last_ch = 1'b0;
            if (gap && p != NI - 1) begin
                step();
                chk("pix_hold", 32'(o_pix_cnt), p + 1);
            end
        end
    endtask

    // which: expected table; bp: toggle i_ready; vin: hold i_valid high; stop_n: transfers
    task automatic drain(input int which, input bit bp, input bit vin, input int stop_n);
        logic [AW-1:0] ex;
        int n = 0;
        int cyc = 0;
        chk("lat_valid0", 32'(o_valid), 0);
        chk("ready_drain0", 32'(o_ready), 0);
        step();
        while (n < stop_n && cyc < 200) begin
            ex = (which == 1) ? e1[n] : (which == 2) ? e2[n] : e3[n];
            i_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            i_valid = vin;
            i_prod_col = {NK{16'h0007}};
            chk("o_valid", 32'(o_valid), 1);
            chk("o_ready_drain", 32'(o_ready), 0);
            chk("o_data", 32'(o_data), 32'(ex));
            chk("o_last", 32'(o_last), 32'(n == OW - 1));
            chk("pix_drain", 32'(o_pix_cnt), 0);
            if (o_valid && i_ready) n++;
            step();
            cyc++;
            i_valid = 1'b0;
        end
        i_ready = 1'b1;
        if (n < stop_n) chk("drain_timeout", n, stop_n);
        if (stop_n == OW) begin
            chk("end_valid", 32'(o_valid), 0);
            chk("end_ready", 32'(o_ready), 1);
            chk("end_last", 32'(o_last), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        e1 = '{1, 2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 1};
        for (int j = 0; j < OW; j++) begin
            e2[j] = e1[j] * 2;
            e3[j] = AW'(0) - e1[j];
        end
        i_rst = 1'b1; i_prod_col = '0; i_valid = 1'b0; i_last_ch = 1'b0; i_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_last", 32'(o_last), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_pix", 32'(o_pix_cnt), 0);
        i_rst = 1'b0;
        step();

        // single channel, all ones
        send_row(16'h0001, 1'b1, 1'b0);
        drain(1, 1'b0, 1'b0, OW);

        // two channels: no drain after the first pass
        send_row(16'h0001, 1'b0, 1'b0);
        chk("ch0_novalid", 32'(o_valid), 0);
        step();
        chk("ch0_novalid2", 32'(o_valid), 0);
        chk("ch0_ready", 32'(o_ready), 1);
        send_row(16'h0001, 1'b1, 1'b0);
        drain(2, 1'b0, 1'b0, OW);

        // all -1: sign extension and wrap
        step();
        send_row(16'hFFFF, 1'b1, 1'b0);
        drain(3, 1'b0, 1'b0, OW);

        // backpressure with i_valid held high during drain
        send_row(16'h0001, 1'b1, 1'b0);
        drain(1, 1'b1, 1'b1, OW);
        step();
        send_row(16'h0001, 1'b1, 1'b0);
        drain(1, 1'b0, 1'b0, OW);

        // async reset after 5 transfers
        send_row(16'hFFFF, 1'b1, 1'b0);
        drain(3, 1'b0, 1'b0, 5);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_ready", 32'(o_ready), 1);
        chk("mid_rst_last", 32'(o_last), 0);
        chk("mid_rst_pix", 32'(o_pix_cnt), 0);
        step();
        i_rst = 1'b0;
        step();
        send_row(16'h0001, 1'b1, 1'b0);
        drain(1, 1'b0, 1'b0, OW);

        // valid every other cycle
        send_row(16'h0001, 1'b1, 1'b1);
        drain(1, 1'b0, 1'b0, OW);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
